// File: rtl/cordic_rot_seq.sv
// Iterative 16-bit CORDIC rotation-mode sequencer: quadrant pre-rotation followed by
// N_ITER shift-add micro-rotations, with the arctangent supplied by an external table.
module cordic_rot_seq #(
    parameter int N_ITER = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] y_in,
    input  logic signed [15:0] z_in,
    output logic        [4:0]  iter_count,
    input  logic signed [15:0] angle_constant,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] x_out,
    output logic signed [15:0] y_out,
    output logic signed [15:0] z_out,
    output logic               busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PREROT = 2'd1;
    localparam logic [1:0] S_ROTATE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [4:0]         LAST_ITER = 5'(N_ITER - 1);
    localparam logic signed [15:0] QUARTER   = 16'sd16384;

    logic        [1:0]  r_state;
    logic        [4:0]  r_iter;
    logic signed [15:0] r_x, r_y, r_z;
    logic signed [15:0] r_x_out, r_y_out, r_z_out;

    logic signed [15:0] w_x_sh, w_y_sh;
    logic signed [15:0] w_x_rot, w_y_rot, w_z_rot;
    logic signed [15:0] w_x_pre, w_y_pre, w_z_pre;

    // One micro-rotation; both updates use the pre-iteration x and y.
    always_comb begin
        w_x_sh = r_x >>> r_iter;
        w_y_sh = r_y >>> r_iter;
        if (!r_z[15]) begin
            w_x_rot = r_x - w_y_sh;
            w_y_rot = r_y + w_x_sh;
            w_z_rot = r_z - angle_constant;
        end else begin
            w_x_rot = r_x + w_y_sh;
            w_y_rot = r_y - w_x_sh;
            w_z_rot = r_z + angle_constant;
        end
    end

    // Quadrant fold into +-90 deg so the micro-rotations can converge.
    always_comb begin
        w_x_pre = r_x;
        w_y_pre = r_y;
        w_z_pre = r_z;
        if (r_z > QUARTER) begin
            w_x_pre = -r_y;
            w_y_pre = r_x;
            w_z_pre = r_z - QUARTER;
        end else if (r_z < -QUARTER) begin
            w_x_pre = r_y;
            w_y_pre = -r_x;
            w_z_pre = r_z + QUARTER;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_iter  <= 5'd0;
            r_x_out <= '0;
            r_y_out <= '0;
            r_z_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) r_state <= S_PREROT;
                end
                S_PREROT: begin
                    r_state <= S_ROTATE;
                    r_iter  <= 5'd0;
                end
                S_ROTATE: begin
                    if (r_iter == LAST_ITER) begin
                        r_state <= S_DONE;
                        r_iter  <= 5'd0;
                        r_x_out <= w_x_rot;
                        r_y_out <= w_y_rot;
                        r_z_out <= w_z_rot;
                    end else begin
                        r_iter <= r_iter + 5'd1;
                    end
                end
                default: begin
                    if (out_ready) r_state <= S_IDLE;
                end
            endcase
        end
    end

    // NOTE: working registers carry no reset; every path loads them before they are observed.
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    r_x <= x_in;
                    r_y <= y_in;
                    r_z <= z_in;
                end
            end
            S_PREROT: begin
                r_x <= w_x_pre;
                r_y <= w_y_pre;
                r_z <= w_z_pre;
            end
            S_ROTATE: begin
                r_x <= w_x_rot;
                r_y <= w_y_rot;
                r_z <= w_z_rot;
            end
            default: ;
        endcase
    end

    assign in_ready   = (r_state == S_IDLE) && !rst;
    assign busy       = (r_state != S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign iter_count = r_iter;
    assign x_out      = r_x_out;
    assign y_out      = r_y_out;
    assign z_out      = r_z_out;

endmodule

// File: tb/tb_cordic_rot_seq.sv
// Self-checking bench for cordic_rot_seq: cycle-level latency/handshake model plus an
// arithmetic CORDIC reference, driven by directed vectors and randomized traffic.
module tb_cordic_rot_seq;

    localparam int N = 14;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic signed [15:0] x_in = '0, y_in = '0, z_in = '0;
    logic               in_ready, out_valid, busy;
    logic        [4:0]  iter_count;
    logic signed [15:0] angle_constant;
    logic signed [15:0] x_out, y_out, z_out;

    typedef struct {
        int x;
        int y;
        int z;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    cordic_rot_seq #(.N_ITER(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .iter_count(iter_count), .angle_constant(angle_constant),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // atan(2^-i) scaled so that 8192 = 45 deg; zero from 14 on.
    function automatic logic signed [15:0] atan_tab(input logic [4:0] i);
        case (i)
            5'd0:    return 16'sd8192;
            5'd1:    return 16'sd4836;
            5'd2:    return 16'sd2555;
            5'd3:    return 16'sd1297;
            5'd4:    return 16'sd651;
            5'd5:    return 16'sd326;
            5'd6:    return 16'sd163;
            5'd7:    return 16'sd81;
            5'd8:    return 16'sd41;
            5'd9:    return 16'sd20;
            5'd10:   return 16'sd10;
            5'd11:   return 16'sd5;
            5'd12:   return 16'sd3;
            5'd13:   return 16'sd1;
            default: return 16'sd0;
        endcase
    endfunction

    assign angle_constant = atan_tab(iter_count);

    function automatic int wrap16(input int v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    function automatic vec_t cordic_ref(input int x0, input int y0, input int z0);
        vec_t r;
        int x, y, z, t, xs, ys;
        x = x0; y = y0; z = z0;
        if (z > 16384) begin
            t = wrap16(-y); y = x; x = t; z = z - 16384;
        end else if (z < -16384) begin
            t = y; y = wrap16(-x); x = t; z = z + 16384;
        end
        for (int i = 0; i < N; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            if (z >= 0) begin
                x = wrap16(x - ys); y = wrap16(y + xs);
                z = wrap16(z - int'(atan_tab(5'(i))));
            end else begin
                x = wrap16(x + ys); y = wrap16(y - xs);
                z = wrap16(z + int'(atan_tab(5'(i))));
            end
        end
        r.x = x; r.y = y; r.z = z;
        return r;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_tol(input string name, input int got, input int exp, input int tol);
        int d;
        n_checks++;
        d = (got > exp) ? got - exp : exp - got;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d +-%0d", name, got, exp, tol);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT at t=%0t", name, $time);
    endtask

    // Cycle model: phase counter since acceptance; result appears at phase N+2.
    bit   m_init = 0;
    bit   m_active = 0;
    int   m_k = 0;
    vec_t m_res = '{0, 0, 0};
    vec_t m_out = '{0, 0, 0};

    always @(negedge clk) begin
        int exp_iter;
        if (m_init) begin
            exp_iter = (m_active && m_k >= 2 && m_k <= N + 1) ? m_k - 2 : 0;
            check("in_ready",   int'(in_ready),   int'(!rst && !m_active));
            check("busy",       int'(busy),       int'(m_active));
            check("out_valid",  int'(out_valid),  int'(m_active && m_k >= N + 2));
            check("iter_count", int'(iter_count), exp_iter);
            check("x_out",      int'(x_out),      m_out.x);
            check("y_out",      int'(y_out),      m_out.y);
            check("z_out",      int'(z_out),      m_out.z);
        end
        if (rst) begin
            m_init = 1; m_active = 0; m_k = 0; m_out = '{0, 0, 0};
        end else if (!m_active) begin
            if (in_valid) begin
                m_active = 1; m_k = 1;
                m_res = cordic_ref(int'(x_in), int'(y_in), int'(z_in));
            end
        end else if (m_k >= N + 2) begin
            if (out_ready) m_active = 0;
        end else begin
            m_k++;
            if (m_k == N + 2) m_out = m_res;
        end
    end

    int hs_q[$];
    always @(negedge clk) if (!rst && in_valid && in_ready) hs_q.push_back(cyc);

    task automatic run_op(input int x, input int y, input int z, output vec_t r, output int lat);
        int t, t0;
        r = '{0, 0, 0};
        lat = -1;
        @(posedge clk); #1;
        x_in = 16'(x); y_in = 16'(y); z_in = 16'(z);
        in_valid = 1'b1; out_ready = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 40);
        if (!in_ready) begin
            timeout_fail("run_op_accept");
            in_valid = 1'b0;
            return;
        end
        t0 = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 40);
        if (!out_valid) begin
            timeout_fail("run_op_result");
            return;
        end
        lat = cyc - t0;
        r.x = int'(x_out); r.y = int'(y_out); r.z = int'(z_out);
    endtask

    task automatic wait_idle();
        int t;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy || out_valid) && t < 100);
        if (busy || out_valid) timeout_fail("wait_idle");
    endtask

    initial begin
        vec_t r, v;
        int   lat, t, seen;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_x_out",    int'(x_out),    0);

        // Pin the reference model with hand-derived values.
        v = cordic_ref(9949, 0, 0);
        check("model_x0", v.x, 16383);
        check("model_y0", v.y, 4);
        check("model_z0", v.z, -1);
        v = cordic_ref(9949, 0, 8192);
        check_tol("model_x45", v.x, 11585, 4);
        check_tol("model_y45", v.y, 11585, 4);

        run_op(9949, 0, 0, r, lat);
        check("latency", lat, N + 2);
        check_tol("x_0deg", r.x, 16384, 4);
        check_tol("y_0deg", r.y, 0, 4);
        check_tol("z_0deg", r.z, 0, 2);

        run_op(9949, 0, 8192, r, lat);
        check_tol("x_45deg", r.x, 11585, 4);
        check_tol("y_45deg", r.y, 11585, 4);

        run_op(9949, 0, 24576, r, lat);
        check_tol("x_135deg", r.x, -11585, 4);
        check_tol("y_135deg", r.y, 11585, 4);

        run_op(9949, 0, -24576, r, lat);
        check_tol("x_m135deg", r.x, -11585, 4);
        check_tol("y_m135deg", r.y, -11585, 4);

        run_op(0, 9949, -32768, r, lat);
        check_tol("x_180deg", r.x, 0, 6);
        check_tol("y_180deg", r.y, -16384, 6);
        wait_idle();

        // Backpressure: hold out_ready low in DONE while offering new operands.
        @(posedge clk); #1;
        x_in = 16'sd5000; y_in = -16'sd3000; z_in = 16'sd1234;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 40);
        if (!out_valid) timeout_fail("bp_result");
        r.x = int'(x_out); r.y = int'(y_out); r.z = int'(z_out);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; x_in = 16'sd100; y_in = 16'sd200; z_in = 16'sd300;
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready",  int'(in_ready),  0);
            check("bp_x_stable",  int'(x_out),     r.x);
            check("bp_z_stable",  int'(z_out),     r.z);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        wait_idle();

        // Back-to-back traffic with out_ready held high.
        hs_q.delete();
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b1;
        x_in = 16'sd7000; y_in = 16'sd7000; z_in = -16'sd5000;
        repeat (3 * (N + 3) + 2) @(posedge clk);
        #1 in_valid = 1'b0;
        wait_idle();
        check("b2b_count", hs_q.size(), 4);
        for (int k = 0; k + 1 < hs_q.size(); k++)
            check("b2b_spacing", hs_q[k + 1] - hs_q[k], N + 3);

        // Reset in the cycle iter_count is 6 aborts the operation.
        @(posedge clk); #1;
        in_valid = 1'b1; x_in = 16'sd9949; y_in = 16'sd0; z_in = 16'sd4000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (iter_count != 5'd5 && t < 40);
        if (iter_count != 5'd5) timeout_fail("reset_wait_iter5");
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_iter_at_6", int'(iter_count), 6);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", int'(out_valid),  0);
        check("abort_iter",      int'(iter_count), 0);
        check("abort_busy",      int'(busy),       0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_result", seen, 0);

        // Randomized traffic, including angle boundaries and random backpressure.
        for (int k = 0; k < 1500; k++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            x_in = 16'(int'($urandom_range(0, 28000)) - 14000);
            y_in = 16'(int'($urandom_range(0, 28000)) - 14000);
            case ($urandom_range(0, 9))
                0:       z_in = -16'sd32768;
                1:       z_in = 16'sd16384;
                2:       z_in = 16'sd16385;
                3:       z_in = -16'sd16384;
                4:       z_in = -16'sd16385;
                default: z_in = 16'($urandom);
            endcase
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
